// File: rtl/jt5205_feeder_if.sv
// ROM read bus between the ADPCM feeder (master) and the sample ROM (slave).
// cs/ok handshake: master holds rom_cs with a stable rom_addr until rom_ok.
interface jt5205_feeder_if #(
    parameter int AW = 16
);
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok;

    modport master (output rom_addr, output rom_cs, input rom_data, input rom_ok);
    modport slave  (input rom_addr, input rom_cs, output rom_data, output rom_ok);
endinterface

// File: rtl/jt5205_feeder.sv
// jt5205_feeder: fetches packed ADPCM bytes from ROM into a 2-byte prefetch
// buffer and hands one nibble to the MSM5205 decoder per sample strobe.
// Optional macro JT5205_FEEDER_LOOP_EN: endless looping playback instead of
// one-shot; only stop or reset ends a looped sample.
module jt5205_feeder #(
    parameter int AW       = 16,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic          vclk_in,
    jt5205_feeder_if.master rom,
    output logic [3:0]    din,
    output logic          busy,
    output logic          done,
    output logic          underrun
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;      // next byte to fetch
    logic [AW-1:0] base_q, base_d;    // latched start address (loop reload)
    logic [AW-1:0] end_q, end_d;
    logic          cs_q, cs_d;
    logic          cs_prev_q, cs_prev_d;
    logic [7:0]    buf0_q, buf0_d;    // buffer head
    logic [7:0]    buf1_q, buf1_d;
    logic          last0_q, last0_d;  // entry holds the end byte
    logic          last1_q, last1_d;
    logic [1:0]    cnt_q, cnt_d;      // bytes held, 0..2
    logic          phase_q, phase_d;  // 0 = first nibble of head byte next
    logic [3:0]    din_q, din_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;
    logic          fetched_q, fetched_d; // end byte already fetched
    logic          eos_q, eos_d;      // last nibble of the end byte is out

    logic          capture;
    logic          strobe;
    logic          pop;
    logic          last_hit;
    logic          one_shot_end;
    logic [1:0]    cnt_mid;
    logic [3:0]    nib_first;
    logic [3:0]    nib_second;

    assign nib_first  = HI_FIRST ? buf0_q[7:4] : buf0_q[3:0];
    assign nib_second = HI_FIRST ? buf0_q[3:0] : buf0_q[7:4];

    // Next-state: control, fetch handshake, buffer and nibble output.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        base_d     = base_q;
        end_d      = end_q;
        cs_d       = cs_q;
        cs_prev_d  = cs_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        last0_d    = last0_q;
        last1_d    = last1_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        din_d      = din_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        fetched_d  = fetched_q;
        eos_d      = eos_q;
        pop        = 1'b0;
        cnt_mid    = cnt_q;
        // ok only counts once cs has been up a full cycle, so a leftover ok
        // from the previous address is never captured.
        capture    = cs_q & cs_prev_q & rom.rom_ok;
        strobe     = (state_q == ST_PLAY) & vclk_in;
        last_hit   = (ptr_q == end_q);
`ifdef JT5205_FEEDER_LOOP_EN
        one_shot_end = 1'b0;
`else
        one_shot_end = strobe & eos_q;
`endif

        if (stop) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cs_d    = 1'b0;
        end else if (start) begin
            // Restart: any outstanding request is dropped (cs low one cycle).
            state_d    = ST_LOAD;
            ptr_d      = start_addr;
            base_d     = start_addr;
            end_d      = end_addr;
            cs_d       = 1'b0;
            busy_d     = 1'b1;
            underrun_d = 1'b0;
            cnt_d      = 2'd0;
            phase_d    = 1'b0;
            fetched_d  = 1'b0;
            eos_d      = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (strobe && eos_q) begin
                done_d = 1'b1;
                eos_d  = 1'b0;
            end
            if (one_shot_end) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                din_d   = 4'd0;
                cs_d    = 1'b0;
            end else begin
                if (strobe) begin
                    if (cnt_q == 2'd0) begin
                        underrun_d = 1'b1;
                    end else begin
                        din_d   = phase_q ? nib_second : nib_first;
                        phase_d = ~phase_q;
                        if (phase_q) begin
                            pop = 1'b1;
                            if (last0_q) eos_d = 1'b1;
                        end
                    end
                end
                if (pop) begin
                    buf0_d  = buf1_q;
                    last0_d = last1_q;
                    cnt_mid = cnt_q - 2'd1;
                end
                if (capture) begin
                    if (cnt_mid == 2'd0) begin
                        buf0_d  = rom.rom_data;
                        last0_d = last_hit;
                    end else begin
                        buf1_d  = rom.rom_data;
                        last1_d = last_hit;
                    end
                    cnt_mid = cnt_mid + 2'd1;
                    cs_d    = 1'b0;
                    ptr_d   = ptr_q + 1'b1;
                    if (last_hit) begin
`ifdef JT5205_FEEDER_LOOP_EN
                        // Wrap the fetch pointer now so the next pass is
                        // already prefetched when the end-of-sample strobe hits.
                        ptr_d = base_q;
`else
                        fetched_d = 1'b1;
`endif
                    end
                end else if (!cs_q && !fetched_q && cnt_q != 2'd2) begin
                    cs_d = 1'b1;
                end
                cnt_d = cnt_mid;
                if (state_q == ST_LOAD && (cnt_q == 2'd2 || fetched_q))
                    state_d = ST_PLAY;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            base_q     <= '0;
            end_q      <= '0;
            cs_q       <= 1'b0;
            cs_prev_q  <= 1'b0;
            buf0_q     <= 8'd0;
            buf1_q     <= 8'd0;
            last0_q    <= 1'b0;
            last1_q    <= 1'b0;
            cnt_q      <= 2'd0;
            phase_q    <= 1'b0;
            din_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            fetched_q  <= 1'b0;
            eos_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            base_q     <= base_d;
            end_q      <= end_d;
            cs_q       <= cs_d;
            cs_prev_q  <= cs_prev_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            last0_q    <= last0_d;
            last1_q    <= last1_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            din_q      <= din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            fetched_q  <= fetched_d;
            eos_q      <= eos_d;
        end
    end

    // rom_cs is gated by reset so a request drops in the very cycle reset is seen.
    assign rom.rom_cs   = cs_q & rst_n;
    assign rom.rom_addr = ptr_q;
    assign din          = din_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign underrun     = underrun_q;
endmodule
